// File: rtl/uart_line_echo_if.sv
// UART FIFO-side bundle for the line echo stage: RX pop, TX push and line status.
// master = echo stage, slave = UART FIFO pair / observer.
interface uart_line_echo_if #(
   parameter int ADDR_W = 4
);
   logic             rx_empty;
   logic [7:0]       r_data;
   logic             rd_uart;
   logic             tx_full;
   logic [7:0]       w_data;
   logic             wr_uart;
   logic [ADDR_W:0]  line_len;
   logic             busy;
   logic             overflow;

   modport master (
      input  rx_empty, r_data, tx_full,
      output rd_uart, w_data, wr_uart, line_len, busy, overflow
   );

   modport slave (
      output rx_empty, r_data, tx_full,
      input  rd_uart, w_data, wr_uart, line_len, busy, overflow
   );
endinterface

// File: rtl/uart_line_echo.sv
// Line-buffered UART echo with backspace editing; pops/pushes combinationally gated by FIFO flags,
// state updates at the next edge, one byte per cycle, tx_full stalls SEND/SEND_CR/SEND_LF in place.
module uart_line_echo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   uart_line_echo_if.master u
);
   typedef enum logic [1:0] {
      S_COLLECT,
      S_SEND,
      S_SEND_CR,
      S_SEND_LF
   } state_t;

   localparam logic [ADDR_W:0]   LEN_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   state_t            r_state;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_ovf;
   logic [7:0]        r_buf [DEPTH];

   logic              w_rd;
   logic              w_wr;
   logic [7:0]        w_tx_byte;
   logic              w_last;

   assign w_rd   = (r_state == S_COLLECT) && !u.rx_empty;
   assign w_wr   = (r_state != S_COLLECT) && !u.tx_full;
   // rd_ptr stops at the last byte instead of stepping past it, so it stays within DEPTH-1
   assign w_last = ({1'b0, r_ptr} == (r_len - LEN_ONE));

   always_comb begin
      w_tx_byte = 8'h00;
      case (r_state)
         S_SEND:    w_tx_byte = r_buf[r_ptr];
         S_SEND_CR: w_tx_byte = 8'h0D;
         S_SEND_LF: w_tx_byte = 8'h0A;
         default:   w_tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_COLLECT;
         r_len   <= '0;
         r_ptr   <= '0;
         r_ovf   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'h00;
      end else begin
         case (r_state)
            S_COLLECT: begin
               if (w_rd) begin
                  case (u.r_data)
                     8'h0D: begin
                        if (r_len == '0) begin
                           r_state <= S_SEND_CR;
                        end else begin
                           r_ptr   <= '0;
                           r_state <= S_SEND;
                        end
                     end
                     8'h0A: ;
                     8'h08, 8'h7F: begin
                        if (r_len != '0) r_len <= r_len - LEN_ONE;
                     end
                     default: begin
                        if (r_len < LEN_FULL) begin
                           r_buf[r_len[ADDR_W-1:0]] <= u.r_data;
                           r_len <= r_len + LEN_ONE;
                        end else begin
                           r_ovf <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            S_SEND: begin
               if (w_wr) begin
                  if (w_last) r_state <= S_SEND_CR;
                  else        r_ptr   <= r_ptr + PTR_ONE;
               end
            end
            S_SEND_CR: begin
               if (w_wr) r_state <= S_SEND_LF;
            end
            S_SEND_LF: begin
               if (w_wr) begin
                  r_len   <= '0;
                  r_ovf   <= 1'b0;
                  r_state <= S_COLLECT;
               end
            end
            default: r_state <= S_COLLECT;
         endcase
      end
   end

   assign u.rd_uart  = w_rd;
   assign u.wr_uart  = w_wr;
   assign u.w_data   = w_wr ? w_tx_byte : 8'h00;
   assign u.line_len = r_len;
   assign u.busy     = (r_state != S_COLLECT);
   assign u.overflow = r_ovf;
endmodule

// File: tb/tb_uart_line_echo.sv
// Directed bench for uart_line_echo: models the RX/TX FIFOs cycle by cycle, samples at negedge+1.
module tb_uart_line_echo;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_line_echo_if #(.ADDR_W(4)) u_if ();

   uart_line_echo #(.DEPTH(16), .ADDR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .u     (u_if)
   );

   logic [7:0] rxq [$];
   logic [7:0] txq [$];
   logic [7:0] expq [$];
   int n_vec = 0;
   int n_err = 0;
   int busy_cyc, rd_cyc, rd_busy, both_cyc, wdata_bad, stall_low, len_max;
   int first_ovf, first_push, last_push, pops, stall_at, stall_rem;

   task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      busy_cyc = 0; rd_cyc = 0; rd_busy = 0; both_cyc = 0; wdata_bad = 0;
      stall_low = 0; len_max = 0; first_ovf = -1; first_push = -1; last_push = -1;
      pops = 0;
      txq.delete();
   endtask

   // One loop iteration per clock: drive at negedge, sample 1 ns later, commit pop/push.
   task automatic run(input int stop_pushes);
      int  cyc  = 0;
      bit  done = 0;
      while (!done) begin
         @(negedge clk);
         u_if.rx_empty = (rxq.size() == 0);
         u_if.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
         u_if.tx_full  = (stall_at > 0) && (txq.size() >= stall_at) && (stall_rem > 0);
         if (u_if.tx_full) stall_rem--;
         #1;
         if (u_if.busy) busy_cyc++;
         if (u_if.rd_uart) rd_cyc++;
         if (u_if.rd_uart && u_if.busy) rd_busy++;
         if (u_if.rd_uart && u_if.wr_uart) both_cyc++;
         if (!u_if.wr_uart && (u_if.w_data != 8'h00)) wdata_bad++;
         if (u_if.tx_full && !u_if.wr_uart) stall_low++;
         if (int'(u_if.line_len) > len_max) len_max = int'(u_if.line_len);
         if (u_if.overflow && (first_ovf < 0)) first_ovf = pops;
         if (u_if.wr_uart) begin
            if (first_push < 0) first_push = cyc;
            last_push = cyc;
            txq.push_back(u_if.w_data);
         end
         if (u_if.rd_uart) begin
            void'(rxq.pop_front());
            pops++;
         end
         if ((stop_pushes > 0) && (txq.size() >= stop_pushes)) done = 1;
         else if ((rxq.size() == 0) && !u_if.busy && !u_if.rd_uart) done = 1;
         cyc++;
         if (cyc > 2000) begin
            chk_vec("timeout", 32'd1, 32'd0);
            done = 1;
         end
      end
   endtask

   task automatic cmp_tx(input string tag);
      chk_vec({tag, "_txlen"}, txq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < txq.size(); i++)
         chk_vec($sformatf("%s_tx%0d", tag, i), txq[i], expq[i]);
   endtask

   task automatic cmp_common(input string tag);
      chk_vec({tag, "_both"},  both_cyc, 0);
      chk_vec({tag, "_wdat0"}, wdata_bad, 0);
      chk_vec({tag, "_len0"},  u_if.line_len, 0);
      chk_vec({tag, "_ovf0"},  u_if.overflow, 0);
   endtask

   initial begin
      u_if.rx_empty = 1'b1;
      u_if.r_data   = 8'h00;
      u_if.tx_full  = 1'b0;
      stall_at = 0; stall_rem = 0;
      repeat (2) @(negedge clk);
      #1;
      chk_vec("rst_rd",   u_if.rd_uart, 0);
      chk_vec("rst_wr",   u_if.wr_uart, 0);
      chk_vec("rst_wdat", u_if.w_data, 8'h00);
      chk_vec("rst_len",  u_if.line_len, 0);
      chk_vec("rst_busy", u_if.busy, 0);
      chk_vec("rst_ovf",  u_if.overflow, 0);
      @(negedge clk);
      reset = 1'b0;

      // 'A','B',CR
      clear_stats();
      rxq  = '{8'h41, 8'h42, 8'h0D};
      expq = '{8'h41, 8'h42, 8'h0D, 8'h0A};
      run(0);
      cmp_tx("ab");
      cmp_common("ab");
      chk_vec("ab_rd",     rd_cyc, 3);
      chk_vec("ab_busy",   busy_cyc, 4);
      chk_vec("ab_lenmax", len_max, 2);
      chk_vec("ab_consec", last_push - first_push, 3);

      // backspace editing
      clear_stats();
      rxq  = '{8'h41, 8'h58, 8'h08, 8'h42, 8'h0D};
      expq = '{8'h41, 8'h42, 8'h0D, 8'h0A};
      run(0);
      cmp_tx("bs");
      cmp_common("bs");
      chk_vec("bs_lenmax", len_max, 2);

      // DEL on empty line, then CR
      clear_stats();
      rxq  = '{8'h7F, 8'h08, 8'h0D};
      expq = '{8'h0D, 8'h0A};
      run(0);
      cmp_tx("bse");
      cmp_common("bse");
      chk_vec("bse_lenmax", len_max, 0);
      chk_vec("bse_busy",   busy_cyc, 2);

      // overflow: seventeen 'a' then CR
      clear_stats();
      rxq.delete();
      expq.delete();
      for (int i = 0; i < 17; i++) rxq.push_back(8'h61);
      rxq.push_back(8'h0D);
      for (int i = 0; i < 16; i++) expq.push_back(8'h61);
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
      run(0);
      cmp_tx("ovf");
      cmp_common("ovf");
      chk_vec("ovf_lenmax", len_max, 16);
      chk_vec("ovf_rise",   first_ovf, 17);
      chk_vec("ovf_busy",   busy_cyc, 18);

      // tx_full stall for 5 cycles after first push; RX bytes wait during SEND
      clear_stats();
      stall_at = 1; stall_rem = 5;
      rxq  = '{8'h48, 8'h49, 8'h0D, 8'h51, 8'h0D};
      expq = '{8'h48, 8'h49, 8'h0D, 8'h0A, 8'h51, 8'h0D, 8'h0A};
      run(0);
      stall_at = 0;
      cmp_tx("stl");
      cmp_common("stl");
      chk_vec("stl_low",    stall_low, 5);
      chk_vec("stl_rdbusy", rd_busy, 0);
      chk_vec("stl_rd",     rd_cyc, 5);

      // LF bytes discarded while collecting
      clear_stats();
      rxq  = '{8'h41, 8'h0A, 8'h42, 8'h0D};
      expq = '{8'h41, 8'h42, 8'h0D, 8'h0A};
      run(0);
      cmp_tx("lf");
      cmp_common("lf");

      // async reset after first pushed byte of a 3-byte line
      clear_stats();
      rxq = '{8'h61, 8'h62, 8'h63, 8'h0D};
      run(1);
      chk_vec("ar_pre_tx", txq[0], 8'h61);
      u_if.rx_empty = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk_vec("ar_rd",   u_if.rd_uart, 0);
      chk_vec("ar_wr",   u_if.wr_uart, 0);
      chk_vec("ar_wdat", u_if.w_data, 8'h00);
      chk_vec("ar_len",  u_if.line_len, 0);
      chk_vec("ar_busy", u_if.busy, 0);
      chk_vec("ar_ovf",  u_if.overflow, 0);
      @(negedge clk);
      reset = 1'b0;

      clear_stats();
      rxq  = '{8'h5A, 8'h0D};
      expq = '{8'h5A, 8'h0D, 8'h0A};
      run(0);
      cmp_tx("ar_z");
      cmp_common("ar_z");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
